// File: rtl/serial_addsub.sv
// serial_addsub -- bit-serial adder/subtractor, LSB first, one result bit per clock.
//
// A single 1-bit full-add cell and a carry register walk the latched operands
// from the LSB to the MSB. For subtract, B and the carry-in are inverted when
// the operands are latched, so the cell computes a + ~b + ~cin = a - b - cin.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (overrides start)
//   start  in   request; a, b, cin, s_op latched when accepted (IDLE or DONE only)
//   s_op   in   0 = add, 1 = subtract
//   a, b   in   WIDTH-bit operands
//   cin    in   carry-in (add) / borrow-in (subtract)
//   busy   out  high during the WIDTH bit-cycles of an operation
//   done   out  one-cycle pulse when s/cout (/ovf) are valid
//   s      out  result, held until the edge after the next accepted start
//   cout   out  final carry; in subtract mode 1 = no borrow
//   ovf    out  signed overflow (only when SERIAL_ADDSUB_OVF_EN is defined)
//
// Build option: define SERIAL_ADDSUB_OVF_EN to add the ovf port and its logic.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one result bit per cycle; cnt counts bit-cycles left down to 0
// DONE  | result valid, done pulses; start here chains a new operation

module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             last_bit;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             sum_bit;
    logic             carry_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The single full-add cell.
    assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            // Subtract folds into add here: ~b and ~cin, so the cell never
            // needs to know the operation.
            a_sh  <= a;
            b_sh  <= s_op ? ~b : b;
            carry <= s_op ? ~cin : cin;
            cnt   <= CW'(WIDTH - 1);
        end else if (busy) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= carry_nxt;
            cnt   <= cnt - CW'(1);
            // Result bits enter at the MSB and drift down; after WIDTH
            // shifts bit 0 of the result sits in s[0].
            s     <= {sum_bit, s[WIDTH-1:1]};
            if (last_bit) begin
                cout <= carry_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
                // carry into the MSB is the current carry register value
                ovf  <= carry ^ carry_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance: directed scenarios
    logic       rst8 = 1'b1, start8 = 1'b0, op8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] s8;

    // WIDTH=16 instance: random operations
    logic        rst16 = 1'b1, start16 = 1'b0, op16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] s16;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .s_op(op8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .s_op(op16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .s(s16), .cout(cout16)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf16)
`endif
    );

`ifndef SERIAL_ADDSUB_OVF_EN
    assign ovf8  = 1'b0;
    assign ovf16 = 1'b0;
`endif

    typedef struct {
        logic [63:0] s;
        bit          co;
        bit          ov;
        int          t;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    int checks   = 0;
    int failures = 0;

    bit zero8_req = 0, hold8_req = 0, end_req = 0, tmo_req = 0;
    logic [63:0] last_s8 = '0;
    int run8 = 0, run16 = 0;

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input bit c, input bit op, input int t);
        exp_t   e;
        longint m    = (longint'(1) << w) - 1;
        longint half = m >> 1;
        longint ua   = longint'(a) & m;
        longint ub   = longint'(b) & m;
        longint lc   = longint'(c);
        longint sa, sb, sr, full;
        if (!op) begin
            full = ua + ub + lc;
            e.co = (full > m);
            e.s  = 64'(full & m);
        end else begin
            e.co = (ua >= ub + lc);
            e.s  = 64'((ua - ub - lc) & m);
        end
        sa   = (ua > half) ? ua - (m + 1) : ua;
        sb   = (ub > half) ? ub - (m + 1) : ub;
        sr   = op ? (sa - sb - lc) : (sa + sb + lc);
        e.ov = (sr > half) || (sr < -half - 1);
        e.t  = t;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor / scoreboard. Done is expected WIDTH edges after the accepting
    // edge (cycle T+WIDTH+1 counting the accepting edge as cycle T's end),
    // preceded by exactly WIDTH busy cycles.
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            chk("dut8_busy_done_exclusive", busy8, 0);
            chk("dut8_done_expected", q8.size() != 0, 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("dut8_s", s8, e.s);
                chk("dut8_cout", cout8, e.co);
`ifdef SERIAL_ADDSUB_OVF_EN
                chk("dut8_ovf", ovf8, e.ov);
`endif
                chk("dut8_latency_edges", cyc - e.t, 8);
                chk("dut8_busy_cycles", run8, 8);
                last_s8 = e.s;
            end
        end
        if (done16) begin
            chk("dut16_busy_done_exclusive", busy16, 0);
            chk("dut16_done_expected", q16.size() != 0, 1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                chk("dut16_s", s16, e.s);
                chk("dut16_cout", cout16, e.co);
`ifdef SERIAL_ADDSUB_OVF_EN
                chk("dut16_ovf", ovf16, e.ov);
`endif
                chk("dut16_latency_edges", cyc - e.t, 16);
                chk("dut16_busy_cycles", run16, 16);
            end
        end
        run8  = busy8  ? run8 + 1  : 0;
        run16 = busy16 ? run16 + 1 : 0;
        if (zero8_req) begin
            chk("dut8_zero_s", s8, 0);
            chk("dut8_zero_cout", cout8, 0);
            chk("dut8_zero_ovf", ovf8, 0);
            chk("dut8_zero_busy", busy8, 0);
            chk("dut8_zero_done", done8, 0);
        end
        if (hold8_req) chk("dut8_hold_s", s8, last_s8);
        if (tmo_req) begin
            checks++;
            failures++;
            $display("FAIL timeout waiting for done at cycle %0d", cyc);
        end
        if (end_req) begin
            chk("dut8_queue_drained", q8.size(), 0);
            chk("dut16_queue_drained", q16.size(), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on dut8; caller guarantees it is in IDLE or DONE.
    task automatic go8(input bit op, input logic [7:0] a, input logic [7:0] b, input bit c,
                       input bit expect_done);
        op8 = op; a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        if (expect_done) q8.push_back(model(8, 64'(a), 64'(b), c, op, cyc + 1));
        step();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); op8 = 1'($urandom);
    endtask

    task automatic go16(input bit op, input logic [15:0] a, input logic [15:0] b, input bit c);
        op16 = op; a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        q16.push_back(model(16, 64'(a), 64'(b), c, op, cyc + 1));
        step();
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); op16 = 1'($urandom);
    endtask

    task automatic flag_timeout();
        step();
        tmo_req = 1;
        step();
        tmo_req = 0;
    endtask

    // Returns at the falling edge of the done cycle, so a follow-on request
    // is sampled on the very next rising edge.
    task automatic wait8();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done8) seen = 1;
        end
        if (!seen) flag_timeout();
    endtask

    task automatic wait16();
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done16) seen = 1;
        end
        if (!seen) flag_timeout();
    endtask

    initial begin
        step();
        step();
        rst8 = 1'b0;
        rst16 = 1'b0;
        zero8_req = 1;
        step();
        zero8_req = 0;

        // carry out of the top, wraps to zero
        go8(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1);
        wait8();
        repeat (3) step();
        hold8_req = 1;
        step();
        hold8_req = 0;

        // borrow case, then signed overflow in both directions
        go8(1'b1, 8'h05, 8'h07, 1'b0, 1'b1);
        wait8();
        step();
        go8(1'b0, 8'h7F, 8'h01, 1'b0, 1'b1);
        wait8();
        step();
        go8(1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
        wait8();
        step();
        go8(1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
        wait8();
        step();

        // starts with fresh operands on every busy cycle must be ignored
        go8(1'b0, 8'h12, 8'h34, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            start8 = 1'b1;
            a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom); cin8 = 1'($urandom);
            step();
        end
        start8 = 1'b0;
        wait8();
        step();

        // abort mid-run, with a start asserted alongside the reset
        go8(1'b0, 8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (3) step();
        rst8 = 1'b1;
        start8 = 1'b1;
        step();
        rst8 = 1'b0;
        start8 = 1'b0;
        zero8_req = 1;
        step();
        zero8_req = 0;
        repeat (12) step();
        go8(1'b0, 8'h3C, 8'h0F, 1'b1, 1'b1);
        wait8();

        // back-to-back: second start lands in the done cycle
        step();
        go8(1'b0, 8'h01, 8'h01, 1'b0, 1'b1);
        wait8();
        go8(1'b0, 8'h10, 8'h20, 1'b0, 1'b1);
        wait8();
        step();

        // random traffic on the 16-bit instance, mixing chained and gapped requests
        for (int n = 0; n < 1000; n++) begin
            go16(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            wait16();
            if ($urandom_range(1, 0) == 0) begin
                repeat ($urandom_range(2, 1)) step();
            end
        end

        repeat (4) step();
        end_req = 1;
        step();
        end_req = 0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; operands sampled when accepted.
- s_op  input  1  operation select: 0 = add, 1 = subtract.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (subtract).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- s  output  WIDTH  result, held until the next accepted start.
- cout  output  1  final carry; in subtract mode 1 = no borrow.
- ovf  output  1  signed overflow; present only with SERIAL_ADDSUB_OVF_EN.

Function
REQ-003 SHALL compute one result bit per clock using a single 1-bit full add/subtract cell and a carry register (bit-serial, LSB first).
REQ-004 SHALL implement add as a + b + cin.
REQ-005 SHALL implement subtract as a + ~b + ~cin, giving a - b - cin modulo 2^WIDTH.
REQ-006 SHALL use FSM states IDLE, RUN and DONE.
- IDLE -> RUN on start.
- RUN -> DONE after exactly WIDTH bit-cycles.
- DONE -> RUN on start; otherwise DONE -> IDLE.
REQ-007 SHALL accept start only in IDLE or DONE, latching a, b, cin and s_op on that edge.
- Later changes to those inputs SHALL NOT affect the operation in progress.
REQ-008 SHALL ignore start while busy; no error and no state change.
REQ-009 SHALL drive timing as follows, with start accepted at edge T:
- busy high from T+1 through T+WIDTH.
- done high only in cycle T+WIDTH+1.
- s, cout (and ovf) valid from T+WIDTH+1.
REQ-010 SHALL keep s, cout (and ovf) stable from done until the edge after the next accepted start; they MAY change during RUN.
REQ-011 SHALL support back-to-back operation: start in the DONE cycle begins a new operation with no idle cycle, giving throughput of one result per WIDTH+1 cycles.
REQ-012 SHALL take cout from the carry register after the MSB cycle; no bit beyond WIDTH is retained.
REQ-013 SHALL keep done and busy mutually exclusive.

Reset
REQ-014 SHALL, when rst is sampled high, force on the next edge: state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0 (if present), carry register=0.
REQ-015 SHALL treat rst asserted mid-RUN as an abort: no done pulse and partial results discarded.
REQ-016 SHALL give rst priority over start in the same cycle; that start is not accepted.

Configuration
REQ-017 SHALL use macro SERIAL_ADDSUB_OVF_EN.
- Defined: port ovf exists, equal to carry-into-MSB XOR carry-out-of-MSB captured in the final bit-cycle (two's-complement overflow for both add and subtract).
- Undefined: no ovf port and no associated logic; all other behaviour is identical.

Verification
REQ-018 SHALL pass these directed scenarios, each at WIDTH=8 unless stated:
- Add a=0xFF, b=0x01, cin=0, start at T -> done at T+9, s=0x00, cout=1; busy high T+1..T+8.
- Subtract a=0x05, b=0x07, cin=0 -> s=0xFE, cout=0 (borrow); with OVF_EN, ovf=0.
- With OVF_EN, add 0x7F+0x01 -> s=0x80, ovf=1; subtract 0x80-0x01 -> s=0x7F, ovf=1.
- Start pulses with new operands every cycle during RUN -> ignored; result matches the first operation and exactly one done pulse occurs.
- rst asserted at T+4 of an operation -> next cycle all outputs 0 and state IDLE; no done follows; a fresh start then completes normally.
- Back-to-back: start in the done cycle with 0x10+0x20 after 0x01+0x01 -> s=0x02 at first done; s=0x30 exactly 9 cycles later; no idle gap.
- WIDTH=16 instance: random add/subtract against a reference model over 1000 operations -> exact s/cout (and ovf) match, latency WIDTH+1.
